// File: rtl/gf12_pad_pkg.sv
// Shared types and reset constants for the GF12 bidirectional pad sequencer.
package gf12_pad_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTx   = 2'd1,
    StTurn = 2'd2,
    StRx   = 2'd3
  } state_e;

  // {DS1, DS0}
  typedef logic [1:0] ds_t;

  localparam ds_t  DsRst = 2'b01;
  localparam logic SrRst = 1'b0;

endpackage

// File: rtl/gf12_pad_rx_pipe.sv
// Receive capture pipeline: DEPTH stages of pad data with a matching valid tag.
// DEPTH=2 acts as a two-flop synchronizer, DEPTH=1 as a plain capture register.
module gf12_pad_rx_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/gf12_bidir_pad_seq.sv
// Half-duplex sequencer for a bank of GF12 FS_DR bidirectional pads.
// Define GF12_PAD_SEQ_RX_SYNC_EN for a two-flop synchronizer on pad_y (rx latency 2, else 1).
module gf12_bidir_pad_seq
  import gf12_pad_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [1:0]       i_cfg_ds,
  input  logic             i_cfg_sr,
  input  logic             i_tx_valid,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_tx_ready,
  input  logic             i_rx_req,
  output logic             o_rx_valid,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_pad_a,
  output logic             o_pad_oe,
  output logic             o_pad_ie,
  output logic             o_pad_ds0,
  output logic             o_pad_ds1,
  output logic             o_pad_sr,
  input  logic [WIDTH-1:0] i_pad_y
);

`ifdef GF12_PAD_SEQ_RX_SYNC_EN
  localparam int unsigned RxDepth = 2;
`else
  localparam int unsigned RxDepth = 1;
`endif

  localparam int unsigned     CntW     = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYC - 1);

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_last_tx, w_last_tx_d;
  logic            r_busy;
  logic [WIDTH-1:0] r_pad_a;
  ds_t             r_pend_ds, r_pad_ds, w_ds;
  logic            r_pend_sr, r_pad_sr, w_sr;
  logic            w_idle, w_oe, w_ie;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_last_tx_d = r_last_tx;
    unique case (r_state)
      StIdle: begin
        // On a tie the side not granted last time wins.
        if (i_tx_valid && (!i_rx_req || !r_last_tx)) begin
          w_state_d   = StTx;
          w_last_tx_d = 1'b1;
        end else if (i_rx_req) begin
          w_state_d   = StRx;
          w_last_tx_d = 1'b0;
        end
      end
      StTx: begin
        // The TX cycle that sees tx_valid low is already the first dead cycle.
        if (!i_tx_valid) begin
          if (TURN_CYC > 1) begin
            w_state_d = StTurn;
            w_cnt_d   = TurnLoad;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StTurn: begin
        w_cnt_d = r_cnt - CntW'(1);
        if (r_cnt <= CntW'(1)) begin
          w_state_d = StIdle;
        end
      end
      StRx: begin
        if (!i_rx_req) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_last_tx <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_last_tx <= w_last_tx_d;
      r_busy    <= (w_state_d != StIdle);
    end
  end

  assign w_idle = (r_state == StIdle);
  assign w_oe   = (r_state == StTx) && i_tx_valid;
  assign w_ie   = (r_state == StRx);

  // Pads follow the pending config only while idle, so OE/IE are never active across a change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_ds <= DsRst;
      r_pend_sr <= SrRst;
      r_pad_ds  <= DsRst;
      r_pad_sr  <= SrRst;
      r_pad_a   <= '0;
    end else begin
      if (i_cfg_valid) begin
        r_pend_ds <= i_cfg_ds;
        r_pend_sr <= i_cfg_sr;
      end
      if (w_idle) begin
        r_pad_ds <= r_pend_ds;
        r_pad_sr <= r_pend_sr;
      end
      if (w_oe) begin
        r_pad_a <= i_tx_data;
      end
    end
  end

  assign w_ds = w_idle ? r_pend_ds : r_pad_ds;
  assign w_sr = w_idle ? r_pend_sr : r_pad_sr;

  assign o_pad_oe   = w_oe;
  assign o_pad_ie   = w_ie;
  assign o_tx_ready = w_oe;
  assign o_pad_a    = w_oe ? i_tx_data : r_pad_a;
  assign o_busy     = r_busy;
  assign o_pad_ds0  = w_ds[0];
  assign o_pad_ds1  = w_ds[1];
  assign o_pad_sr   = w_sr;

  gf12_pad_rx_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (RxDepth)
  ) u_rx_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_pad_y),
    .i_valid (w_ie),
    .o_data  (o_rx_data),
    .o_valid (o_rx_valid)
  );

endmodule
